monitor_host_agent: RTL and testbench
=====================================

MONITOR_HOST_AGENT -- requirements
Module: monitor_host_agent

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYC, default 1000000, giving the number of clk_run_i cycles allowed between response bytes.
REQ-002 The module SHALL have parameter TIMEOUT_W, default 20, giving the width of the timeout counter.
REQ-003 The module SHALL have port clk_run_i, input, width 1: the clock.
REQ-004 The module SHALL have port rst_n, input, width 1: reset, asynchronous, active-low.
REQ-005 The module SHALL have port req_valid_i, input, width 1: request offered.
REQ-006 The module SHALL have port req_ready_o, output, width 1: request accepted when both req_valid_i and req_ready_o are 1.
REQ-007 The module SHALL have port req_op_i, input, width 3: opcode (0 NOP, 1 RUN, 2 STOP, 3 RESET, 4 REG_RD, 5 REG_WR, 6 MEM_RD, 7 MEM_WR).
REQ-008 The module SHALL have port req_addr_i, input, width 10: register index in bits [4:0], or memory word address.
REQ-009 The module SHALL have port req_wdata_i, input, width 32: write data.
REQ-010 The module SHALL have port tx_byte_o, input/output direction output, width 8: outgoing command byte.
REQ-011 The module SHALL have port tx_valid_o, output, width 1: outgoing byte valid.
REQ-012 The module SHALL have port tx_ready_i, input, width 1: the outgoing byte is accepted when both tx_valid_o and tx_ready_i are 1.
REQ-013 The module SHALL have port rx_byte_i, input, width 8: incoming response byte.
REQ-014 The module SHALL have port rx_valid_i, input, width 1: incoming byte valid.
REQ-015 The module SHALL have port rx_ready_o, output, width 1: tied to 1, so all incoming bytes are accepted.
REQ-016 The module SHALL have port rsp_valid_o, output, width 1: a one-cycle completion pulse.
REQ-017 The module SHALL have port rsp_data_o, output, width 32: read result.
REQ-018 The module SHALL have port rsp_timeout_o, output, width 1: the completion ended by timeout.
REQ-019 The module SHALL have port busy_o, output, width 1: high whenever the state is not IDLE.

Function
REQ-020 The FSM states SHALL be IDLE, CMD, ADDR, DATA, WAIT_RSP and DONE.
REQ-021 req_ready_o SHALL be 1 only in IDLE; on acceptance the module SHALL latch op, addr and wdata and go to CMD.
REQ-022 The command byte SHALL be {op[2:0], addr[4:0]}.
REQ-023 For MEM_RD and MEM_WR, addr[4:0] SHALL be replaced by 0 in the command byte.
REQ-024 A byte SHALL be held stable on tx_byte_o while tx_valid_o=1, and SHALL advance only on the cycle the handshake completes.
REQ-025 After CMD, MEM_RD and MEM_WR SHALL go to ADDR and send 2 bytes: {6'b0, addr[9:8]}, then addr[7:0].
REQ-026 After CMD or ADDR, REG_WR and MEM_WR SHALL go to DATA and send wdata in 4 bytes, MSB first.
REQ-027 After the last byte is sent, REG_RD and MEM_RD SHALL go to WAIT_RSP; all other opcodes SHALL go to DONE.
REQ-028 In WAIT_RSP the module SHALL shift 4 received bytes, MSB first, into the result word; after the 4th byte it SHALL go to DONE.
REQ-029 A 2-bit byte counter SHALL be shared by the ADDR, DATA and WAIT_RSP states, and SHALL be cleared on every state entry.
REQ-030 The timeout counter SHALL run only in WAIT_RSP, be cleared on state entry and on every received byte, and saturate at TIMEOUT_CYC-1.
REQ-031 If the timeout counter reaches TIMEOUT_CYC-1 with no byte received that cycle, the module SHALL go to DONE with rsp_timeout_o=1 and rsp_data_o=0.
REQ-032 If a byte arrives in the same cycle as the timeout expiry, the byte SHALL win and the counter SHALL clear.
REQ-033 In DONE the module SHALL assert rsp_valid_o for exactly 1 cycle, then return to IDLE.
REQ-034 rsp_data_o and rsp_timeout_o SHALL hold their values until the next DONE.
REQ-035 For non-read ops, rsp_data_o SHALL be 0.
REQ-036 Bytes received outside WAIT_RSP SHALL be dropped, and each dropped byte SHALL increment an internal 8-bit saturating stray counter.
REQ-037 The minimum latency for NOP, RUN, STOP and RESET SHALL be: accept at cycle T, tx_valid_o at T+1, and with tx_ready_i=1 rsp_valid_o at T+2.
REQ-038 req_valid_i SHALL be ignored while busy_o=1; no queuing SHALL be performed.

Reset
REQ-039 While rst_n=0, the state SHALL be IDLE, the counters 0, and the latched registers 0.
REQ-040 While rst_n=0, req_ready_o SHALL be 0 and tx_valid_o, rsp_valid_o and rsp_timeout_o SHALL be 0.
REQ-041 While rst_n=0, tx_byte_o and rsp_data_o SHALL be 0.
REQ-042 A reset asserted mid-transaction SHALL abort it immediately, with no rsp_valid_o pulse.
REQ-043 req_ready_o SHALL rise on the first clk_run_i edge after rst_n is released.

Structure
REQ-044 The opcode constants, the state encoding and the command-byte field positions SHALL be placed in the shared package monitor_pkg, because the command decoder uses the same opcodes.
REQ-045 The timeout counter SHALL be implemented in one sub-module, mon_timeout_cnt, with ports clr, en and expired; everything else SHALL stay in a single module.

Verification
REQ-046 A RUN request with tx_ready_i=1 SHALL produce exactly one byte, 0x20, followed by rsp_valid_o with rsp_data_o=0 and rsp_timeout_o=0.
REQ-047 A REG_RD of addr=5 SHALL send 0x85; response bytes 0xDE,0xAD,0xBE,0xEF SHALL give rsp_data_o=0xDEADBEEF.
REQ-048 A MEM_WR of addr=0x3A7 with wdata=0x12345678 and tx_ready_i toggling every cycle SHALL produce the bytes 0xE0,0x03,0xA7,0x12,0x34,0x56,0x78, each held stable while stalled.
REQ-049 A MEM_RD with TIMEOUT_CYC=16 and only 2 response bytes SHALL produce rsp_valid_o 16 cycles after the 2nd byte, with rsp_timeout_o=1 and rsp_data_o=0.
REQ-050 A byte arriving in the expiry cycle SHALL produce no timeout, and the transaction SHALL complete normally on the 4th byte.
REQ-051 rst_n pulsed low during DATA SHALL produce tx_valid_o=0 and busy_o=0 with no rsp_valid_o, and a new NOP request SHALL then complete normally.

Source files
------------

// File: rtl/monitor_pkg.sv
// rtl/monitor_pkg.sv - opcodes, FSM encoding and command-byte layout shared with the command decoder
package monitor_pkg;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_RUN    = 3'd1;
    localparam logic [2:0] OP_STOP   = 3'd2;
    localparam logic [2:0] OP_RESET  = 3'd3;
    localparam logic [2:0] OP_REG_RD = 3'd4;
    localparam logic [2:0] OP_REG_WR = 3'd5;
    localparam logic [2:0] OP_MEM_RD = 3'd6;
    localparam logic [2:0] OP_MEM_WR = 3'd7;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CMD      = 3'd1;
    localparam logic [2:0] ST_ADDR     = 3'd2;
    localparam logic [2:0] ST_DATA     = 3'd3;
    localparam logic [2:0] ST_WAIT_RSP = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    localparam int CMD_OP_LSB = 5;
    localparam int CMD_IDX_W  = 5;

    function automatic logic is_mem_op(input logic [2:0] op);
        return (op == OP_MEM_RD) || (op == OP_MEM_WR);
    endfunction

    // Memory ops carry their address in the ADDR bytes, so the index field is zeroed.
    function automatic logic [7:0] cmd_byte(input logic [2:0] op, input logic [CMD_IDX_W-1:0] idx);
        logic [7:0] b;
        b = '0;
        b[CMD_OP_LSB +: 3] = op;
        if (!is_mem_op(op)) begin
            b[CMD_IDX_W-1:0] = idx;
        end
        return b;
    endfunction

endpackage

// File: rtl/mon_timeout_cnt.sv
// rtl/mon_timeout_cnt.sv - saturating response-gap counter for the monitor host agent
module mon_timeout_cnt #(
    parameter int TIMEOUT_CYC = 1000000,
    parameter int TIMEOUT_W   = 20
) (
    input  logic clk_run_i,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = TIMEOUT_W'(TIMEOUT_CYC - 1);

    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_run_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == CNT_MAX);

endmodule

// File: rtl/monitor_host_agent.sv
// rtl/monitor_host_agent.sv - serialises monitor requests into command bytes and collects read responses
module monitor_host_agent
    import monitor_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000000,
    parameter int TIMEOUT_W   = 20
) (
    input  logic        clk_run_i,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_op_i,
    input  logic [9:0]  req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic [7:0]  tx_byte_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    input  logic [7:0]  rx_byte_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_timeout_o,
    output logic        busy_o
);

    logic [2:0]  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [9:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [23:0] shift_q, shift_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [7:0]  stray_q, stray_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_to_q, rsp_to_d;
    logic        init_q;
    logic        tx_hs, is_rd, expired;

    assign tx_hs = tx_valid_o && tx_ready_i;
    assign is_rd = (op_q == OP_REG_RD) || (op_q == OP_MEM_RD);

    mon_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TIMEOUT_W   (TIMEOUT_W)
    ) u_timeout (
        .clk_run_i (clk_run_i),
        .rst_n     (rst_n),
        .clr       ((state_q != ST_WAIT_RSP) || rx_valid_i),
        .en        (state_q == ST_WAIT_RSP),
        .expired   (expired)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        shift_d    = shift_q;
        bcnt_d     = bcnt_q + 2'd1;
        stray_d    = stray_q;
        rsp_data_d = rsp_data_q;
        rsp_to_d   = rsp_to_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    op_d    = req_op_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (tx_hs) begin
                    if (is_mem_op(op_q))        state_d = ST_ADDR;
                    else if (op_q == OP_REG_WR) state_d = ST_DATA;
                    else if (op_q == OP_REG_RD) state_d = ST_WAIT_RSP;
                    else                        state_d = ST_DONE;
                end
            end
            ST_ADDR: begin
                if (tx_hs && (bcnt_q == 2'd1)) begin
                    state_d = (op_q == OP_MEM_WR) ? ST_DATA : ST_WAIT_RSP;
                end
            end
            ST_DATA: begin
                if (tx_hs && (bcnt_q == 2'd3)) begin
                    state_d = is_rd ? ST_WAIT_RSP : ST_DONE;
                end
            end
            ST_WAIT_RSP: begin
                // A byte landing in the expiry cycle takes priority over the timeout.
                if (rx_valid_i) begin
                    shift_d = {shift_q[15:0], rx_byte_i};
                    if (bcnt_q == 2'd3) begin
                        state_d    = ST_DONE;
                        rsp_data_d = {shift_q, rx_byte_i};
                        rsp_to_d   = 1'b0;
                    end
                end else if (expired) begin
                    state_d    = ST_DONE;
                    rsp_data_d = '0;
                    rsp_to_d   = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if ((state_q != ST_WAIT_RSP) && (state_d == ST_DONE)) begin
            rsp_data_d = '0;
            rsp_to_d   = 1'b0;
        end
        if (rx_valid_i && (state_q != ST_WAIT_RSP) && (stray_q != 8'hFF)) begin
            stray_d = stray_q + 8'd1;
        end
        // The byte counter only advances on a byte moving in its current state.
        if (state_d != state_q) begin
            bcnt_d = '0;
        end else if (!((state_q == ST_WAIT_RSP) ? rx_valid_i : (tx_hs && (state_q != ST_CMD)))) begin
            bcnt_d = bcnt_q;
        end
    end

    always_ff @(posedge clk_run_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            shift_q    <= '0;
            bcnt_q     <= '0;
            stray_q    <= '0;
            rsp_data_q <= '0;
            rsp_to_q   <= 1'b0;
            init_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            shift_q    <= shift_d;
            bcnt_q     <= bcnt_d;
            stray_q    <= stray_d;
            rsp_data_q <= rsp_data_d;
            rsp_to_q   <= rsp_to_d;
            init_q     <= 1'b1;
        end
    end

    always_comb begin
        tx_byte_o = '0;
        case (state_q)
            ST_CMD:  tx_byte_o = cmd_byte(op_q, addr_q[CMD_IDX_W-1:0]);
            ST_ADDR: tx_byte_o = bcnt_q[0] ? addr_q[7:0] : {6'b0, addr_q[9:8]};
            ST_DATA: begin
                case (bcnt_q)
                    2'd0:    tx_byte_o = wdata_q[31:24];
                    2'd1:    tx_byte_o = wdata_q[23:16];
                    2'd2:    tx_byte_o = wdata_q[15:8];
                    default: tx_byte_o = wdata_q[7:0];
                endcase
            end
            default: tx_byte_o = '0;
        endcase
    end

    assign req_ready_o   = init_q && (state_q == ST_IDLE);
    assign tx_valid_o    = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA);
    assign rx_ready_o    = 1'b1;
    assign rsp_valid_o   = (state_q == ST_DONE);
    assign rsp_data_o    = rsp_data_q;
    assign rsp_timeout_o = rsp_to_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_monitor_host_agent.sv
// tb/tb_monitor_host_agent.sv - scoreboard bench for monitor_host_agent with directed vectors
module tb_monitor_host_agent;

    localparam int TO_CYC = 16;

    logic        clk_run_i   = 1'b0;
    logic        rst_n       = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [2:0]  req_op_i    = '0;
    logic [9:0]  req_addr_i  = '0;
    logic [31:0] req_wdata_i = '0;
    logic [7:0]  tx_byte_o;
    logic        tx_valid_o;
    logic        tx_ready_i  = 1'b1;
    logic [7:0]  rx_byte_i   = '0;
    logic        rx_valid_i  = 1'b0;
    logic        rx_ready_o;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic        rsp_timeout_o;
    logic        busy_o;

    monitor_host_agent #(.TIMEOUT_CYC(TO_CYC), .TIMEOUT_W(5)) dut (
        .clk_run_i     (clk_run_i),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_op_i      (req_op_i),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .tx_byte_o     (tx_byte_o),
        .tx_valid_o    (tx_valid_o),
        .tx_ready_i    (tx_ready_i),
        .rx_byte_i     (rx_byte_i),
        .rx_valid_i    (rx_valid_i),
        .rx_ready_o    (rx_ready_o),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_data_o    (rsp_data_o),
        .rsp_timeout_o (rsp_timeout_o),
        .busy_o        (busy_o)
    );

    always #5 clk_run_i = ~clk_run_i;

    int cyc = 0;
    always @(posedge clk_run_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    logic        tx_toggle = 1'b0;
    logic [7:0]  exp_tx[$];
    logic [31:0] exp_data[$];
    logic        exp_to[$];
    int          exp_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compares whatever the DUT presents against the expectation queues.
    always @(negedge clk_run_i) begin
        if (rst_n) begin
            if (busy_o) chk("ready_while_busy", 32'(req_ready_o), 32'd0);
            if (tx_valid_o) begin
                if (exp_tx.size() == 0) begin
                    chk("tx_unexpected", 32'(tx_valid_o), 32'd0);
                end else begin
                    chk("tx_byte", 32'(tx_byte_o), 32'(exp_tx[0]));
                    if (tx_ready_i) void'(exp_tx.pop_front());
                end
            end
            if (rsp_valid_o) begin
                if (exp_data.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid_o), 32'd0);
                end else begin
                    logic [31:0] d;
                    logic        t;
                    int          c;
                    d = exp_data.pop_front();
                    t = exp_to.pop_front();
                    c = exp_cyc.pop_front();
                    chk("rsp_data", rsp_data_o, d);
                    chk("rsp_timeout", 32'(rsp_timeout_o), 32'(t));
                    if (c >= 0) chk("rsp_cycle", 32'(cyc), 32'(c));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk_run_i);
            #1;
            tx_ready_i = tx_toggle ? !tx_ready_i : 1'b1;
        end
    end

    task automatic push_rsp(input logic [31:0] d, input logic t, input int c);
        exp_data.push_back(d);
        exp_to.push_back(t);
        exp_cyc.push_back(c);
    endtask

    task automatic issue(input logic [2:0] op, input logic [9:0] addr, input logic [31:0] wd, output int acc);
        int n;
        n = 0;
        req_op_i    = op;
        req_addr_i  = addr;
        req_wdata_i = wd;
        req_valid_i = 1'b1;
        @(negedge clk_run_i);
        while (!req_ready_o && n < 50) begin
            @(negedge clk_run_i);
            n++;
        end
        if (!req_ready_o) chk("req_accept_wait", 32'(req_ready_o), 32'd1);
        @(posedge clk_run_i);
        #1;
        acc = cyc;
        req_valid_i = 1'b0;
    endtask

    task automatic wait_tx_drain();
        int n;
        n = 0;
        while (exp_tx.size() != 0 && n < 200) begin
            @(negedge clk_run_i);
            n++;
        end
        if (exp_tx.size() != 0) chk("tx_drain_wait", 32'(exp_tx.size()), 32'd0);
        @(posedge clk_run_i);
        #1;
    endtask

    task automatic wait_rsp_drain();
        int n;
        n = 0;
        while (exp_data.size() != 0 && n < 300) begin
            @(negedge clk_run_i);
            n++;
        end
        if (exp_data.size() != 0) chk("rsp_drain_wait", 32'(exp_data.size()), 32'd0);
        @(posedge clk_run_i);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_byte_i  = b;
        rx_valid_i = 1'b1;
        @(posedge clk_run_i);
        #1;
        rx_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b;
        logic [2:0] s_ops[3];
        logic [9:0] s_addr[3];
        logic [7:0] s_byte[3];
        s_ops  = '{3'd0, 3'd2, 3'd3};
        s_addr = '{10'h000, 10'h003, 10'h01F};
        s_byte = '{8'h00, 8'h43, 8'h7F};

        repeat (3) @(posedge clk_run_i);
        @(negedge clk_run_i);
        chk("rst_req_ready", 32'(req_ready_o), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_timeout", 32'(rsp_timeout_o), 32'd0);
        chk("rst_tx_byte", 32'(tx_byte_o), 32'd0);
        chk("rst_rsp_data", rsp_data_o, 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rx_ready", 32'(rx_ready_o), 32'd1);
        @(posedge clk_run_i);
        #1;
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 32'(req_ready_o), 32'd0);
        @(posedge clk_run_i);
        #1;
        chk("ready_first_edge", 32'(req_ready_o), 32'd1);

        // RUN: single byte 0x20, completion two cycles after accept
        exp_tx.push_back(8'h20);
        issue(3'd1, 10'h000, 32'h0, a);
        push_rsp(32'h0, 1'b0, a + 1);
        wait_rsp_drain();

        send_rx(8'h99);

        for (int i = 0; i < 3; i++) begin
            exp_tx.push_back(s_byte[i]);
            issue(s_ops[i], s_addr[i], 32'hFFFF_FFFF, a);
            push_rsp(32'h0, 1'b0, a + 1);
            wait_rsp_drain();
        end

        // REG_RD idx 5
        exp_tx.push_back(8'h85);
        issue(3'd4, 10'h005, 32'h0, a);
        wait_tx_drain();
        push_rsp(32'hDEADBEEF, 1'b0, -1);
        send_rx(8'hDE);
        send_rx(8'hAD);
        send_rx(8'hBE);
        send_rx(8'hEF);
        wait_rsp_drain();

        // REG_WR idx 0x1F
        exp_tx.push_back(8'hBF);
        exp_tx.push_back(8'hCA);
        exp_tx.push_back(8'hFE);
        exp_tx.push_back(8'hF0);
        exp_tx.push_back(8'h0D);
        issue(3'd5, 10'h01F, 32'hCAFEF00D, a);
        push_rsp(32'h0, 1'b0, -1);
        wait_rsp_drain();

        // MEM_WR with tx_ready toggling
        tx_toggle = 1'b1;
        exp_tx.push_back(8'hE0);
        exp_tx.push_back(8'h03);
        exp_tx.push_back(8'hA7);
        exp_tx.push_back(8'h12);
        exp_tx.push_back(8'h34);
        exp_tx.push_back(8'h56);
        exp_tx.push_back(8'h78);
        issue(3'd7, 10'h3A7, 32'h12345678, a);
        push_rsp(32'h0, 1'b0, -1);
        wait_rsp_drain();
        tx_toggle = 1'b0;
        @(posedge clk_run_i);
        #1;

        // MEM_RD ending in timeout after two bytes
        exp_tx.push_back(8'hC0);
        exp_tx.push_back(8'h01);
        exp_tx.push_back(8'h55);
        issue(3'd6, 10'h155, 32'h0, a);
        wait_tx_drain();
        send_rx(8'hA1);
        send_rx(8'hB2);
        b = cyc;
        push_rsp(32'h0, 1'b1, b + TO_CYC);
        wait_rsp_drain();

        // MEM_RD with the second byte landing exactly in the expiry cycle
        exp_tx.push_back(8'hC0);
        exp_tx.push_back(8'h00);
        exp_tx.push_back(8'hFF);
        issue(3'd6, 10'h0FF, 32'h0, a);
        wait_tx_drain();
        push_rsp(32'h11223344, 1'b0, -1);
        send_rx(8'h11);
        repeat (TO_CYC - 1) @(posedge clk_run_i);
        #1;
        send_rx(8'h22);
        send_rx(8'h33);
        send_rx(8'h44);
        wait_rsp_drain();

        // Reset pulse in the middle of DATA
        exp_tx.push_back(8'hA2);
        exp_tx.push_back(8'h01);
        exp_tx.push_back(8'h02);
        exp_tx.push_back(8'h03);
        exp_tx.push_back(8'h04);
        issue(3'd5, 10'h002, 32'h01020304, a);
        for (int n = 0; n < 50 && exp_tx.size() > 2; n++) @(negedge clk_run_i);
        @(posedge clk_run_i);
        #1;
        chk("tx_valid_before_reset", 32'(tx_valid_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_tx_valid", 32'(tx_valid_o), 32'd0);
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid_o), 32'd0);
        exp_tx.delete();
        @(posedge clk_run_i);
        #1;
        rst_n = 1'b1;
        @(posedge clk_run_i);
        #1;
        exp_tx.push_back(8'h00);
        issue(3'd0, 10'h000, 32'h0, a);
        push_rsp(32'h0, 1'b0, a + 1);
        wait_rsp_drain();

        repeat (5) @(posedge clk_run_i);
        #1;
        chk("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
        chk("rsp_queue_empty", 32'(exp_data.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
